pipelined_adder: RTL and testbench

- Parametrised, pipelined add/subtract unit. Successor to the single-bit full-adder cell.
- Splits a WIDTH-bit operation into STAGES ripple chunks. Each chunk is registered, and carry propagates between stages.
- Used by the pipeline datapath (ALU/address paths) where a full-width ripple chain breaks timing.
- Valid/ready handshake on input and output, with a global stall.

---
 rtl/pipelined_adder.sv | 153 +++++++++++++++
 tb/tb_pipelined_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder
//    Pipelined add/subtract unit. A WIDTH-bit operation is split into STAGES
//    ripple chunks of CHUNK = WIDTH/STAGES bits; each chunk is registered and
//    its carry feeds the next stage. A global advance enable implements the
//    valid/ready handshake and stall.
//
// Ports
//    i_clk    clock, rising edge
//    i_rst    asynchronous active-high reset
//    i_valid  input operands valid
//    o_ready  unit accepts an operation this cycle
//    i_a/i_b  operands (WIDTH bits)
//    i_sub    0 = A+B, 1 = A-B
//    o_valid  result valid
//    i_ready  downstream accepts the result
//    o_sum    result modulo 2^WIDTH
//    o_co     carry out of MSB (subtract: 1 = no borrow)
//    o_ovf    signed two's-complement overflow
//    o_zero   o_sum == 0
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_co,
   output logic             o_ovf,
   output logic             o_zero
);

   localparam int CHUNK = WIDTH / STAGES;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
   end

   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
   logic             v_in    [STAGES];
   logic [WIDTH-1:0] a_in    [STAGES];
   logic [WIDTH-1:0] b_in    [STAGES];
   logic [WIDTH-1:0] s_in    [STAGES];
   logic             c_in    [STAGES];

   logic             adv;
   logic             stage_c;
   logic             c_msb;
   logic [WIDTH-1:0] stage_s;

   assign adv     = !o_valid || i_ready;
   assign o_ready = adv;

   assign o_valid = valid_q[STAGES-1];
   assign o_sum   = sum_q[STAGES-1];
   assign o_co    = carry_q[STAGES-1];
   assign o_ovf   = ovf_q;
   assign o_zero  = zero_q;

   // Subtract is A + ~B + 1: B is conditioned once at entry and carried along
   // already inverted, so later stages never need to know the operation.
   always_comb begin
      v_in[0] = i_valid;
      a_in[0] = i_a;
      b_in[0] = i_sub ? ~i_b : i_b;
      s_in[0] = '0;
      c_in[0] = i_sub;
      for (int k = 1; k < STAGES; k++) begin
         v_in[k] = valid_q[k-1];
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         s_in[k] = sum_q[k-1];
         c_in[k] = carry_q[k-1];
      end
   end

   always_comb begin
      stage_c = 1'b0;
      stage_s = '0;
      c_msb   = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = valid_q[k];
         a_d[k]     = a_q[k];
         b_d[k]     = b_q[k];
         sum_d[k]   = sum_q[k];
         carry_d[k] = carry_q[k];
         stage_c    = c_in[k];
         stage_s    = s_in[k];
         for (int j = 0; j < CHUNK; j++) begin
            // The carry into the MSB is needed for the overflow flag.
            if (k * CHUNK + j == WIDTH - 1) begin
               c_msb = stage_c;
            end
            stage_s[k*CHUNK+j] = a_in[k][k*CHUNK+j] ^ b_in[k][k*CHUNK+j] ^ stage_c;
            stage_c = (a_in[k][k*CHUNK+j] & b_in[k][k*CHUNK+j]) |
                      (stage_c & (a_in[k][k*CHUNK+j] ^ b_in[k][k*CHUNK+j]));
         end
         if (adv) begin
            valid_d[k] = v_in[k];
            a_d[k]     = a_in[k];
            b_d[k]     = b_in[k];
            sum_d[k]   = stage_s;
            carry_d[k] = stage_c;
         end
      end
      ovf_d  = adv ? (c_msb ^ carry_d[STAGES-1]) : ovf_q;
      zero_d = adv ? ~|sum_d[STAGES-1] : zero_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v, ordy, ov, ird, sub;
   logic [31:0] a, b, sum;
   logic        co, ovf, zero;

   logic        v8, sub8, rd8;
   logic [7:0]  a8, b8;
   logic        rdy8 [3];
   logic        ov8  [3];
   logic [7:0]  sum8 [3];
   logic        co8  [3];
   logic        ovf8 [3];
   logic        z8   [3];

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(v), .o_ready(ordy),
      .i_a(a), .i_b(b), .i_sub(sub), .o_valid(ov), .i_ready(ird),
      .o_sum(sum), .o_co(co), .o_ovf(ovf), .o_zero(zero));

   pipelined_adder #(.WIDTH(8), .STAGES(1)) u8_1 (
      .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8[0]),
      .i_a(a8), .i_b(b8), .i_sub(sub8), .o_valid(ov8[0]), .i_ready(rd8),
      .o_sum(sum8[0]), .o_co(co8[0]), .o_ovf(ovf8[0]), .o_zero(z8[0]));

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u8_2 (
      .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8[1]),
      .i_a(a8), .i_b(b8), .i_sub(sub8), .o_valid(ov8[1]), .i_ready(rd8),
      .o_sum(sum8[1]), .o_co(co8[1]), .o_ovf(ovf8[1]), .o_zero(z8[1]));

   pipelined_adder #(.WIDTH(8), .STAGES(8)) u8_8 (
      .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8[2]),
      .i_a(a8), .i_b(b8), .i_sub(sub8), .o_valid(ov8[2]), .i_ready(rd8),
      .o_sum(sum8[2]), .o_co(co8[2]), .o_ovf(ovf8[2]), .o_zero(z8[2]));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: {sum, co, ovf, zero}. Overflow from operand/result signs.
   function automatic logic [34:0] model32(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
      logic [31:0] bb;
      logic [32:0] r;
      logic        vo;
      bb = ms ? ~mb : mb;
      r  = {1'b0, ma} + {1'b0, bb} + {32'd0, ms};
      vo = (ma[31] == bb[31]) && (r[31] != ma[31]);
      return {r[31:0], r[32], vo, (r[31:0] == 32'd0)};
   endfunction

   function automatic logic [10:0] model8(input logic [7:0] ma, input logic [7:0] mb, input logic ms);
      logic [7:0] bb;
      logic [8:0] r;
      logic       vo;
      bb = ms ? ~mb : mb;
      r  = {1'b0, ma} + {1'b0, bb} + {8'd0, ms};
      vo = (ma[7] == bb[7]) && (r[7] != ma[7]);
      return {r[7:0], r[8], vo, (r[7:0] == 8'd0)};
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        co;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs [10];

   logic [34:0] sb [$];
   int          takes, first_take, last_take, cyc;

   // Inputs are set by the caller; sample handshake just before the edge.
   task automatic cycle32();
      logic [34:0] e;
      #1;
      if (ov && ird) begin
         if (sb.size() == 0) begin
            check("unexpected output", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("stream result", {sum, co, ovf, zero}, e);
         end
         if (takes == 0) first_take = cyc;
         last_take = cyc;
         takes++;
      end
      if (v && ordy) sb.push_back(model32(a, b, sub));
      @(posedge clk);
      #1;
      cyc++;
   endtask

   logic [7:0] ha [64];
   logic [7:0] hb [64];
   logic       hs [64];
   logic       hv [64];

   initial begin
      int          lat;
      logic [34:0] held;
      int          stale;
      int          n8;
      int          src;
      logic [10:0] e8;
      logic [7:0]  da [8];
      logic [7:0]  db [8];
      logic        ds [8];

      vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; v = 1'b0; a = '0; b = '0; sub = 1'b0; ird = 1'b1;
      v8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; rd8 = 1'b1;
      takes = 0; first_take = 0; last_take = 0; cyc = 0;

      // Reset state
      #12;
      check("reset o_valid", {63'd0, ov}, 64'd0);
      check("reset outputs", {sum, co, ovf, zero}, 64'd0);
      check("reset o_ready", {63'd0, ordy}, 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed table: result and exact latency per vector
      for (int i = 0; i < 10; i++) begin
         a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; v = 1'b1;
         #1;
         check("o_ready before accept", {63'd0, ordy}, 64'd1);
         lat = 0;
         for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            v = 1'b0;
            if (ov) begin
               lat = n;
               break;
            end
         end
         check("latency", lat, 64'd4);
         check("vector sum", sum, vecs[i].sum);
         check("vector flags", {co, ovf, zero}, {vecs[i].co, vecs[i].ovf, vecs[i].zero});
      end
      @(posedge clk);
      #1;

      // Back-to-back stream
      for (int i = 0; i < 8; i++) begin
         v = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
         cycle32();
      end
      v = 1'b0;
      for (int i = 0; i < 12; i++) cycle32();
      check("stream count", takes, 64'd8);
      check("stream contiguous", last_take - first_take, 64'd7);
      check("stream drained", sb.size(), 64'd0);

      // Stall with a full pipeline
      takes = 0;
      for (int i = 0; i < 6; i++) begin
         v = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
         cycle32();
      end
      check("pre-stall o_valid", {63'd0, ov}, 64'd1);
      ird = 1'b0; v = 1'b1; a = 32'hDEADBEEF; b = 32'h13572468; sub = 1'b0;
      #1;
      held = {sum, co, ovf, zero};
      check("stall o_ready", {63'd0, ordy}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall hold", {sum, co, ovf, zero}, held);
         check("stall o_valid", {63'd0, ov}, 64'd1);
         check("stall o_ready", {63'd0, ordy}, 64'd0);
      end
      ird = 1'b1; v = 1'b0;
      for (int i = 0; i < 12; i++) cycle32();
      check("stall count", takes, 64'd6);
      check("stall drained", sb.size(), 64'd0);

      // Reset mid-flight
      for (int i = 0; i < 4; i++) begin
         v = 1'b1; a = $urandom; b = $urandom; sub = 1'b0;
         cycle32();
      end
      check("pre-reset o_valid", {63'd0, ov}, 64'd1);
      #3;
      rst = 1'b1; v = 1'b0;
      #1;
      check("async reset o_valid", {63'd0, ov}, 64'd0);
      check("async reset outputs", {sum, co, ovf, zero}, 64'd0);
      check("async reset o_ready", {63'd0, ordy}, 64'd1);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (ov) stale++;
      end
      check("no stale result", stale, 64'd0);

      // 8-bit builds: STAGES 1, 2, 8 driven by the same stream
      da = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h55, 8'h01};
      db = '{8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h00, 8'hAA, 8'h02};
      ds = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
      n8 = 40;
      for (int t = 0; t < n8 + 9; t++) begin
         if (t < 8) begin
            hv[t] = 1'b1; ha[t] = da[t]; hb[t] = db[t]; hs[t] = ds[t];
         end else if (t < n8) begin
            hv[t] = (t % 5) != 4;
            ha[t] = 8'($urandom); hb[t] = 8'($urandom); hs[t] = 1'($urandom_range(0, 1));
         end else begin
            hv[t] = 1'b0; ha[t] = '0; hb[t] = '0; hs[t] = 1'b0;
         end
         v8 = hv[t]; a8 = ha[t]; b8 = hb[t]; sub8 = hs[t];
         @(posedge clk);
         #1;
         for (int s = 0; s < 3; s++) begin
            src = t + 1 - ((s == 0) ? 1 : (s == 1) ? 2 : 8);
            if (src >= 0 && hv[src]) begin
               e8 = model8(ha[src], hb[src], hs[src]);
               check("w8 valid", {63'd0, ov8[s]}, 64'd1);
               check("w8 result", {sum8[s], co8[s], ovf8[s], z8[s]}, e8);
            end else begin
               check("w8 idle", {63'd0, ov8[s]}, 64'd0);
            end
         end
      end
      v8 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
